writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Owns the single register-file write port. Arbitrates between the in-order pipeline writeback beat and
//  results from long-latency units (multi-cycle MUL/DIV, late loads), which are buffered in a small FIFO.
//  Performs the wb_sel result mux for the pipeline beat, stalls the pipeline when buffered results must drain,
//  and prevents starvation of buffered results. Sits between MEM/WB pipeline register and register file.
// PARAMETERS
//  XLEN          32  datapath width
//  REG_ADDR_W    5   register index width
//  FIFO_DEPTH    4   long-latency result buffer entries (power of 2, >=2)
//  STARVE_LIMIT  8   max consecutive NORMAL cycles a non-empty FIFO may go without a pop
// PORTS
//  clk               in   1           clock; all state updates on rising edge
//  rst               in   1           synchronous, active-high reset
//  pipe_valid        in   1           pipeline writeback beat present
//  pipe_reg_write    in   1           beat writes a register
//  pipe_rd           in   REG_ADDR_W  destination register
//  pipe_wb_sel       in   2           00 ALU, 01 memory, 10 pc+4, 11 ALU
//  pipe_alu_result   in   XLEN        ALU result
//  pipe_memory_data  in   XLEN        load data
//  pipe_pc_plus4     in   XLEN        link value
//  pipe_stall        out  1           beat not accepted; pipeline holds all pipe_* inputs
//  ll_valid          in   1           long-latency result offered
//  ll_rd             in   REG_ADDR_W  its destination
//  ll_data           in   XLEN        its data
//  ll_ready          out  1           FIFO accepts; push when ll_valid && ll_ready
//  rf_we             out  1           register-file write enable (registered)
//  rf_waddr          out  REG_ADDR_W  write address (registered)
//  rf_wdata          out  XLEN        write data (registered)
//  fifo_count        out  log2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO emptied (fifo_count=0), starve_cnt=0, state NORMAL,
//    pipe_stall=0, ll_ready=1. Reset mid-operation discards buffered results without writing them.
//  - rf_* are registered: grant decided in cycle N is visible on rf_* in cycle N+1 (latency 1).
//  - Writes to x0 (rd==0) consume their grant but drive rf_we=0.
//  - FSM (Moore; pipe_stall = state==FORCE_DRAIN; ll_ready = !full && state==NORMAL):
//    NORMAL: pipe beat with pipe_valid&&pipe_reg_write gets the port; else FIFO head pops if non-empty.
//      A beat with pipe_reg_write=0 is accepted without using the port. Go FORCE_DRAIN next cycle when
//      registered fifo_count==FIFO_DEPTH or starve_cnt==STARVE_LIMIT.
//    FORCE_DRAIN: pipe beat not accepted; one pop per cycle; no pushes. Return to NORMAL the cycle after
//      the pop that empties the FIFO.
//  - starve_cnt: in NORMAL increments (saturating) each cycle FIFO non-empty and no pop; cleared on any pop,
//    when FIFO empty, and in FORCE_DRAIN.
//  - Push and pop in same cycle: count unchanged, order preserved (FIFO, head = oldest).
//  - Full: ll_ready=0 even if a pop occurs that cycle (no same-cycle refill when full).
//  - Counters/pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH or underflows.
// CONFIGURATION
//  WB_ARB_BYPASS_EN defined: in NORMAL, if FIFO empty, no pop, no pipe write this cycle and ll_valid, the
//    ll result goes directly to rf_* next cycle without entering the FIFO (count stays 0).
//  Undefined: every ll result is pushed; earliest rf write is 2 cycles after ll_valid.
// STRUCTURE
//  Package riscv_wb_pkg: WB_SEL_ALU/MEM/PC4 encodings, arbiter state encoding (NORMAL, FORCE_DRAIN),
//    shared XLEN/REG_ADDR_W defaults.
//  Sub-module wb_result_fifo: synchronous FIFO of {rd,data}, push/pop/full/empty/count.
// TESTING
//  1 pipe beat wb_sel=10, rd=5, pc_plus4=0x104, no ll traffic -> next cycle rf_we=1, waddr=5, wdata=0x104.
//  2 ll_valid rd=7 data=0xDEAD, pipe idle (no bypass) -> fifo_count=1, then rf write x7=0xDEAD;
//    with WB_ARB_BYPASS_EN -> rf write next cycle, fifo_count stays 0.
//  3 continuous pipe writes + 4 ll pushes -> full, ll_ready=0, pipe_stall=1 for 4 cycles, 4 writes in push
//    order, then NORMAL and pipe write resumes with held beat.
//  4 1 ll entry + continuous pipe writes -> after 8 cycles without pop FORCE_DRAIN, one stall cycle, entry written.
//  5 pipe rd=0 reg_write=1 -> rf_we stays 0; ll rd=0 -> popped, rf_we=0.
//  6 rst asserted with 3 entries buffered and state FORCE_DRAIN -> next cycle all outputs at reset values, no writes.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the writeback stage.
// Contents:
//   XLEN_DEFAULT / REG_ADDR_W_DEFAULT  default datapath and register-index widths
//   wb_sel_e                           pipeline result-select encoding
//   arb_state_e                        writeback arbiter FSM states
package riscv_wb_pkg;

    localparam int unsigned XLEN_DEFAULT       = 32;
    localparam int unsigned REG_ADDR_W_DEFAULT = 5;

    // 2'b11 is an alias of the ALU result.
    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'b00,
        WB_SEL_MEM     = 2'b01,
        WB_SEL_PC4     = 2'b10,
        WB_SEL_ALU_ALT = 2'b11
    } wb_sel_e;

    typedef enum logic [0:0] {
        StNormal     = 1'b0,
        StForceDrain = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering long-latency results as {rd, data} pairs.
// Ports:
//   clk, rst             clock, synchronous active-high reset (empties the FIFO)
//   push, push_rd/data   write an entry (ignored when full)
//   pop                  drop the head entry (ignored when empty)
//   head_rd, head_data   oldest entry, valid while !empty
//   full, empty, count   occupancy status; count ranges 0..DEPTH
module wb_result_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_rd,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [ADDR_W-1:0]      head_rd,
    output logic [DATA_W-1:0]      head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_rd   = rd_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    // Guards keep count inside 0..DEPTH whatever the requester does.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port owner. Arbitrates between the in-order pipeline writeback
// beat and buffered long-latency results (MUL/DIV, late loads), muxes the pipeline
// result by wb_sel, and force-drains the buffer when it fills or starves.
// Optional feature: define WB_ARB_BYPASS_EN to let a long-latency result skip the
// empty FIFO and write the register file on the next cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pipe_valid/reg_write/rd   pipeline writeback beat
//   pipe_wb_sel               00 ALU, 01 memory, 10 pc+4, 11 ALU
//   pipe_alu_result/memory_data/pc_plus4   candidate results
//   pipe_stall                beat not accepted; pipeline holds its inputs
//   ll_valid/rd/data          long-latency result; pushed when ll_valid && ll_ready
//   ll_ready                  buffer accepts a result
//   rf_we/waddr/wdata         registered register-file write port
//   fifo_count                buffer occupancy
module writeback_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_valid,
    input  logic                        pipe_reg_write,
    input  logic [REG_ADDR_W-1:0]       pipe_rd,
    input  logic [1:0]                  pipe_wb_sel,
    input  logic [XLEN-1:0]             pipe_alu_result,
    input  logic [XLEN-1:0]             pipe_memory_data,
    input  logic [XLEN-1:0]             pipe_pc_plus4,
    output logic                        pipe_stall,
    input  logic                        ll_valid,
    input  logic [REG_ADDR_W-1:0]       ll_rd,
    input  logic [XLEN-1:0]             ll_data,
    output logic                        ll_ready,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  fifo_push, fifo_pop;

    logic                  pipe_write;
    logic                  bypass;
    logic [XLEN-1:0]       pipe_wdata;

    logic                  grant_valid;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]       grant_data;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;

    wb_result_fifo #(
        .DATA_W (XLEN),
        .ADDR_W (REG_ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (ll_rd),
        .push_data (ll_data),
        .pop       (fifo_pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // Moore outputs. A full FIFO refuses pushes even in a cycle that pops.
    assign pipe_stall = (state_q == StForceDrain);
    assign ll_ready   = !fifo_full && (state_q == StNormal);
    assign fifo_count = fifo_cnt;

    assign pipe_write = pipe_valid && pipe_reg_write;

    always_comb begin
        pipe_wdata = pipe_alu_result;
        unique case (pipe_wb_sel)
            WB_SEL_MEM: pipe_wdata = pipe_memory_data;
            WB_SEL_PC4: pipe_wdata = pipe_pc_plus4;
            default:    pipe_wdata = pipe_alu_result;
        endcase
    end

`ifdef WB_ARB_BYPASS_EN
    // Port idle and nothing buffered: the result can go straight to the register file.
    assign bypass = (state_q == StNormal) && fifo_empty && !pipe_write && ll_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = ll_valid && ll_ready && !bypass;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        fifo_pop    = 1'b0;
        grant_valid = 1'b0;
        grant_rd    = '0;
        grant_data  = '0;

        unique case (state_q)
            StNormal: begin
                if (pipe_write) begin
                    grant_valid = 1'b1;
                    grant_rd    = pipe_rd;
                    grant_data  = pipe_wdata;
                end else if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    grant_valid = 1'b1;
                    grant_rd    = head_rd;
                    grant_data  = head_data;
                end else if (bypass) begin
                    grant_valid = 1'b1;
                    grant_rd    = ll_rd;
                    grant_data  = ll_data;
                end

                // Counts cycles a waiting head entry is passed over by the pipeline.
                if (fifo_empty || fifo_pop) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end

                if ((fifo_cnt == CNT_W'(FIFO_DEPTH)) || (starve_q == STARVE_W'(STARVE_LIMIT))) begin
                    state_d = StForceDrain;
                end
            end

            StForceDrain: begin
                starve_d = '0;
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    grant_valid = 1'b1;
                    grant_rd    = head_rd;
                    grant_data  = head_data;
                end
                // Leave after the pop that empties the buffer (or if entered already empty).
                if (fifo_empty || (fifo_cnt == CNT_W'(1))) begin
                    state_d = StNormal;
                end
            end

            default: state_d = StNormal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StNormal;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // x0 writes still consume the grant but never assert the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= grant_valid && (grant_rd != '0);
            if (grant_valid) begin
                rf_waddr_q <= grant_rd;
                rf_wdata_q <= grant_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_reg_write;
    logic [4:0]  pipe_rd;
    logic [1:0]  pipe_wb_sel;
    logic [31:0] pipe_alu_result, pipe_memory_data, pipe_pc_plus4;
    logic        pipe_stall;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_valid       (pipe_valid),
        .pipe_reg_write   (pipe_reg_write),
        .pipe_rd          (pipe_rd),
        .pipe_wb_sel      (pipe_wb_sel),
        .pipe_alu_result  (pipe_alu_result),
        .pipe_memory_data (pipe_memory_data),
        .pipe_pc_plus4    (pipe_pc_plus4),
        .pipe_stall       (pipe_stall),
        .ll_valid         (ll_valid),
        .ll_rd            (ll_rd),
        .ll_data          (ll_data),
        .ll_ready         (ll_ready),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .fifo_count       (fifo_count)
    );

    // Scoreboard: every register-file write must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got x%0d=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.addr || rf_wdata !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL rf_write_order: got x%0d=%h, required x%0d=%h",
                             rf_waddr, rf_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pipe_valid       = 1'b0;
        pipe_reg_write   = 1'b0;
        pipe_rd          = '0;
        pipe_wb_sel      = 2'b00;
        pipe_alu_result  = '0;
        pipe_memory_data = '0;
        pipe_pc_plus4    = '0;
        ll_valid         = 1'b0;
        ll_rd            = '0;
        ll_data          = '0;
    endtask

    task automatic push_exp(input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Continuous ALU pipe beats (rd 10+i, data 1000+i) plus n_ll long-latency pushes
    // (rd 20+i, data 2000+i) offered from cycle 0. Beats are held while stalled.
    task automatic run_fill(input int cycles, input int n_beats, input int n_ll,
                            output int stalls, output logic [2:0] cnt4, output logic rdy4);
        int beat = 0;
        int lli  = 0;
        logic acc_p, acc_l;
        stalls = 0;
        cnt4   = '0;
        rdy4   = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            pipe_valid      = (beat < n_beats);
            pipe_reg_write  = 1'b1;
            pipe_wb_sel     = 2'b00;
            pipe_rd         = 5'(10 + beat);
            pipe_alu_result = 32'h1000 + 32'(beat);
            ll_valid        = (lli < n_ll);
            ll_rd           = 5'(20 + lli);
            ll_data         = 32'h2000 + 32'(lli);
            if (pipe_stall) stalls++;
            if (c == 4) begin
                cnt4 = fifo_count;
                rdy4 = ll_ready;
            end
            acc_p = pipe_valid && !pipe_stall;
            acc_l = ll_valid && ll_ready;
            tick();
            if (acc_p) beat++;
            if (acc_l) lli++;
        end
        idle_inputs();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rf: got we=%b waddr=%0d wdata=%h, required 0/0/0",
                     rf_we, rf_waddr, rf_wdata);
        end
        vectors++;
        if (fifo_count !== 3'd0 || pipe_stall !== 1'b0 || ll_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: got count=%0d stall=%b ready=%b, required 0/0/1",
                     fifo_count, pipe_stall, ll_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_wb_sel;
        logic [31:0] exp_d;
        logic [4:0]  rds [4];
        logic [1:0]  sels[4];
        rds[0] = 5'd5;  sels[0] = 2'b10;
        rds[1] = 5'd6;  sels[1] = 2'b00;
        rds[2] = 5'd9;  sels[2] = 2'b01;
        rds[3] = 5'd31; sels[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            pipe_valid       = 1'b1;
            pipe_reg_write   = 1'b1;
            pipe_rd          = rds[i];
            pipe_wb_sel      = sels[i];
            pipe_alu_result  = 32'hAAAA_0000 + 32'(i);
            pipe_memory_data = 32'hBBBB_0000 + 32'(i);
            pipe_pc_plus4    = (i == 0) ? 32'h104 : 32'hCCCC_0000 + 32'(i);
            case (sels[i])
                2'b01:   exp_d = pipe_memory_data;
                2'b10:   exp_d = pipe_pc_plus4;
                default: exp_d = pipe_alu_result;
            endcase
            push_exp(rds[i], exp_d);
            tick();
            vectors++;
            if (rf_we !== 1'b1 || rf_waddr !== rds[i] || rf_wdata !== exp_d) begin
                miscompares++;
                $display("FAIL wb_sel_%0d: got we=%b x%0d=%h, required we=1 x%0d=%h",
                         i, rf_we, rf_waddr, rf_wdata, rds[i], exp_d);
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if (rf_we !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wb_sel_idle: got we=%b pending=%0d, required we=0 pending=0",
                     rf_we, exp_q.size());
        end
    endtask

    task automatic test_ll_single;
        ll_valid = 1'b1;
        ll_rd    = 5'd7;
        ll_data  = 32'hDEAD;
        push_exp(5'd7, 32'hDEAD);
        tick();
        ll_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL ll_bypass: got we=%b x%0d=%h count=%0d, required we=1 x7=dead count=0",
                     rf_we, rf_waddr, rf_wdata, fifo_count);
        end
`else
        vectors++;
        if (fifo_count !== 3'd1 || rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL ll_buffered: got count=%0d we=%b, required count=1 we=0",
                     fifo_count, rf_we);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL ll_write: got we=%b x%0d=%h count=%0d, required we=1 x7=dead count=0",
                     rf_we, rf_waddr, rf_wdata, fifo_count);
        end
`endif
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ll_pending: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_full_drain;
        int         stalls;
        logic [2:0] cnt4;
        logic       rdy4;
        for (int i = 0; i < 5; i++) push_exp(5'(10 + i), 32'h1000 + 32'(i));
        for (int i = 0; i < 4; i++) push_exp(5'(20 + i), 32'h2000 + 32'(i));
        push_exp(5'd15, 32'h1005);
        run_fill(14, 6, 4, stalls, cnt4, rdy4);
        vectors++;
        if (cnt4 !== 3'd4 || rdy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_status: got count=%0d ready=%b, required count=4 ready=0", cnt4, rdy4);
        end
        vectors++;
        if (stalls != 4) begin
            miscompares++;
            $display("FAIL full_stall_cycles: got %0d, required 4", stalls);
        end
        vectors++;
        if (exp_q.size() != 0 || pipe_stall !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL full_end: got pending=%0d stall=%b count=%0d, required 0/0/0",
                     exp_q.size(), pipe_stall, fifo_count);
        end
    endtask

    task automatic test_starve;
        int         stalls = 0;
        int         first_stall = -1;
        int         beat = 0;
        logic       acc_p;
        for (int i = 0; i < 10; i++) push_exp(5'(1 + i), 32'h3000 + 32'(i));
        push_exp(5'd25, 32'h4444);
        push_exp(5'd11, 32'h300A);
        for (int c = 0; c < 14; c++) begin
            pipe_valid      = (beat < 11);
            pipe_reg_write  = 1'b1;
            pipe_wb_sel     = 2'b11;
            pipe_rd         = 5'(1 + beat);
            pipe_alu_result = 32'h3000 + 32'(beat);
            ll_valid        = (c == 0);
            ll_rd           = 5'd25;
            ll_data         = 32'h4444;
            if (pipe_stall) begin
                stalls++;
                if (first_stall < 0) first_stall = c;
            end
            acc_p = pipe_valid && !pipe_stall;
            tick();
            if (acc_p) beat++;
        end
        idle_inputs();
        vectors++;
        if (stalls != 1 || first_stall != 10) begin
            miscompares++;
            $display("FAIL starve_stall: got %0d stalls first at %0d, required 1 at 10",
                     stalls, first_stall);
        end
        vectors++;
        if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL starve_end: got pending=%0d count=%0d, required 0/0",
                     exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_x0;
        int we_seen = 0;
        pipe_valid      = 1'b1;
        pipe_reg_write  = 1'b1;
        pipe_rd         = 5'd0;
        pipe_alu_result = 32'h55;
        tick();
        pipe_reg_write  = 1'b0;
        pipe_rd         = 5'd3;
        tick();
        if (rf_we !== 1'b0) we_seen++;
        idle_inputs();
        ll_valid = 1'b1;
        ll_rd    = 5'd0;
        ll_data  = 32'h77;
        tick();
        if (rf_we !== 1'b0) we_seen++;
        ll_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rf_we !== 1'b0) we_seen++;
        end
        vectors++;
        if (we_seen != 0) begin
            miscompares++;
            $display("FAIL x0_no_write: got rf_we=1 in %0d cycles, required 0", we_seen);
        end
        vectors++;
        if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL x0_end: got count=%0d pending=%0d, required 0/0",
                     fifo_count, exp_q.size());
        end
    endtask

    task automatic test_reset_midop;
        int         stalls;
        logic [2:0] cnt4;
        logic       rdy4;
        for (int i = 0; i < 5; i++) push_exp(5'(10 + i), 32'h1000 + 32'(i));
        push_exp(5'd20, 32'h2000);
        run_fill(6, 6, 4, stalls, cnt4, rdy4);
        vectors++;
        if (pipe_stall !== 1'b1 || fifo_count !== 3'd3) begin
            miscompares++;
            $display("FAIL midop_state: got stall=%b count=%0d, required stall=1 count=3",
                     pipe_stall, fifo_count);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || fifo_count !== 3'd0 ||
            pipe_stall !== 1'b0 || ll_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_reset: got we=%b waddr=%0d wdata=%h count=%0d stall=%b ready=%b, required 0/0/0/0/0/1",
                     rf_we, rf_waddr, rf_wdata, fifo_count, pipe_stall, ll_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (exp_q.size() != 0 || fifo_count !== 3'd0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_after: got pending=%0d count=%0d stall=%b, required 0/0/0",
                     exp_q.size(), fifo_count, pipe_stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_wb_sel();
        test_ll_single();
        test_full_drain();
        test_starve();
        test_x0();
        test_reset_midop();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
